alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//  Parametrised multi-cycle ALU for the stack processor datapath: takes two stack operands and a func code,
//  returns one result plus status flags. Single-cycle ops complete in 1 clock; MUL/DIV/MOD run an iterative
//  shift-add / restoring-division engine over WIDTH cycles. Sits between operand fetch (TOS/NOS) and writeback.
//  Valid/ready handshake on both sides so the control FSM can stall on long ops.
// PARAMETERS
//  WIDTH     16  operand/result width in bits (>=4)
//  FUNC_W    4   func code width
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        operands+func presented
//  in_ready   out  1        ALU can accept a new op
//  func       in   FUNC_W   operation code
//  i0         in   WIDTH    operand 0 (NOS)
//  i1         in   WIDTH    operand 1 (TOS)
//  out_valid  out  1        o0/flags valid
//  out_ready  in   1        consumer takes result
//  o0         out  WIDTH    result
//  flags      out  4        {div0, ovf, carry, zero}
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, o0=0, flags=0, counter=0.
//  Func codes: 0 R1 o0=i0 | 1 R2 o0=i1 | 2 ADD | 3 SUB i0-i1 | 4 MUL low WIDTH bits of i0*i1 (unsigned)
//   | 5 DIV i0/i1 unsigned | 6 MOD i0%i1 unsigned | other: o0=0, flags=0, single-cycle.
//  Accept: transfer when in_valid && in_ready; operands and func registered on that edge.
//  FSM IDLE -> (accept, single-cycle op) DONE; IDLE -> (accept, MUL/DIV/MOD) BUSY; BUSY -> DONE after WIDTH
//   iterations; DONE -> IDLE on out_ready (out_valid && out_ready).
//  Latency from accept edge to out_valid=1: 1 cycle single-cycle ops; WIDTH+1 cycles MUL/DIV/MOD.
//  in_ready=1 only in IDLE; no accept while BUSY/DONE (no pipelining, one op in flight).
//  out_valid held with o0/flags stable until consumed; out_ready ignored when out_valid=0.
//  Simultaneous out_ready handshake and in_valid in DONE: result retired, new op NOT accepted that cycle
//   (in_ready=0 in DONE); accepted next cycle in IDLE.
//  ADD: carry = carry-out of WIDTH-bit sum; ovf = signed overflow. SUB: carry = borrow (i0<i1 unsigned);
//   ovf = signed overflow. MUL: carry = ovf = 1 if upper WIDTH bits of full product nonzero.
//   R1/R2/DIV/MOD: carry=ovf=0. zero = (o0==0) for every op.
//  DIV/MOD by zero: detected at accept, skips iteration, goes BUSY->DONE on next cycle (latency 2);
//   o0 = all-ones (DIV) or i0 (MOD); div0=1, zero per o0.
//  Iteration counter width clog2(WIDTH+1); counter wrap impossible, terminal count = WIDTH-1.
//  rst_n asserted mid-BUSY: operation aborted, all state to reset values; no partial result emitted.
//  Inputs not consumed (in_valid without in_ready) are ignored; i0/i1/func may change freely outside accept.
// STRUCTURE
//  Shared package alu_pkg: func code localparams (ALU_R1..ALU_MOD), FLAG_* bit indices, state encoding.
//  One sub-module: alu_seq_iter -- iterative engine (shift-add MUL, restoring DIV/MOD), start/done
//   interface, WIDTH-parametrised; alu_seq owns handshake FSM, single-cycle ops and flag logic.
// TESTING (WIDTH=16 unless stated)
//  ADD 0xFFFF+0x0001, out_ready=1 -> out_valid 1 cycle after accept, o0=0x0000, flags=zero|carry (0b0011).
//  SUB 0x8000-0x0001 -> o0=0x7FFF, ovf=1, carry=0; SUB 3-5 -> o0=0xFFFE, carry=1.
//  MUL 0x0100*0x0100 -> out_valid 17 cycles after accept, o0=0x0000, carry=ovf=zero=1; MUL 7*6 -> 42.
//  DIV 100/7 -> o0=14; MOD 100%7 -> 2; DIV 5/0 -> latency 2, o0=0xFFFF, div0=1; in_ready=0 throughout.
//  Backpressure: out_ready=0 for 5 cycles after result -> o0/flags stable, in_ready=0; new in_valid
//   in same cycle as retirement accepted one cycle later.
//  rst_n pulse at cycle 8 of a MUL -> out_valid never rises, in_ready=1 after release; next ADD 2+3=5 correct.

Source files
------------

// File: rtl/alu_pkg.sv
// =============================================================================
// Module : alu_pkg
// Brief  : Func codes, flag bit positions and FSM encoding shared by the ALU.
// Rev    : 1.0
// =============================================================================
`default_nettype none

package alu_pkg;

    localparam int unsigned ALU_R1  = 0;
    localparam int unsigned ALU_R2  = 1;
    localparam int unsigned ALU_ADD = 2;
    localparam int unsigned ALU_SUB = 3;
    localparam int unsigned ALU_MUL = 4;
    localparam int unsigned ALU_DIV = 5;
    localparam int unsigned ALU_MOD = 6;

    localparam int unsigned FLAGS_W    = 4;
    localparam int unsigned FLAG_ZERO  = 0;
    localparam int unsigned FLAG_CARRY = 1;
    localparam int unsigned FLAG_OVF   = 2;
    localparam int unsigned FLAG_DIV0  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    function automatic logic [FLAGS_W-1:0] pack_flags(
        input logic div0,
        input logic ovf,
        input logic carry,
        input logic zero
    );
        logic [FLAGS_W-1:0] f;
        f             = '0;
        f[FLAG_DIV0]  = div0;
        f[FLAG_OVF]   = ovf;
        f[FLAG_CARRY] = carry;
        f[FLAG_ZERO]  = zero;
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_iter.sv
// =============================================================================
// Module : alu_seq_iter
// Brief  : Iterative engine: shift-add multiply or restoring divide, one bit per clock.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module alu_seq_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             mode_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] res_lo_o,
    output logic [WIDTH-1:0] res_hi_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic             busy_q, busy_d;
    logic             div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             last_step;

    // hi/lo hold {product high, multiplier/product low} for MUL and
    // {partial remainder, dividend/quotient} for DIV/MOD.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        if (div_q) begin
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    assign last_step = busy_q && (cnt_q == LAST_CNT);

    always_comb begin
        busy_d = busy_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        b_d    = b_q;
        if (start_i) begin
            busy_d = 1'b1;
            div_d  = mode_div_i;
            cnt_d  = '0;
            hi_d   = '0;
            lo_d   = a_i;
            b_d    = b_i;
        end else if (busy_q) begin
            hi_d = step_hi;
            lo_d = step_lo;
            if (last_step) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
        end else begin
            busy_q <= busy_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            b_q    <= b_d;
        end
    end

    // Results are the outcome of the final step, so the owner captures them
    // on the same edge that completes the last iteration.
    assign done_o   = last_step;
    assign res_lo_o = step_lo;
    assign res_hi_o = step_hi;

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// =============================================================================
// Module : alu_seq
// Brief  : Multi-cycle ALU with valid/ready handshake; owns FSM, 1-cycle ops and flags.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int FUNC_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FUNC_W-1:0]  func,
    input  logic [WIDTH-1:0]   i0,
    input  logic [WIDTH-1:0]   i1,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   o0,
    output logic [FLAGS_W-1:0] flags
);

    alu_state_e          state_q, state_d;
    logic [WIDTH-1:0]    o0_q, o0_d;
    logic [FLAGS_W-1:0]  flags_q, flags_d;
    logic [WIDTH-1:0]    i0_q, i0_d;
    logic [FUNC_W-1:0]   func_q, func_d;
    logic                div0_q, div0_d;

    logic [WIDTH:0]      add_w, sub_w;
    logic [WIDTH-1:0]    short_res;
    logic                short_c, short_v, short_known;
    logic [FLAGS_W-1:0]  short_flags;
    logic                is_long, is_divmod, op_div0;

    logic                iter_start, iter_done;
    logic [WIDTH-1:0]    iter_lo, iter_hi;
    logic [WIDTH-1:0]    long_res, div0_res;
    logic                long_v;
    logic [FLAGS_W-1:0]  long_flags, div0_flags;

    assign add_w = {1'b0, i0} + {1'b0, i1};
    assign sub_w = {1'b0, i0} - {1'b0, i1};

    always_comb begin
        short_res   = '0;
        short_c     = 1'b0;
        short_v     = 1'b0;
        short_known = 1'b1;
        is_long     = 1'b0;
        is_divmod   = 1'b0;
        case (func)
            FUNC_W'(ALU_R1):  short_res = i0;
            FUNC_W'(ALU_R2):  short_res = i1;
            FUNC_W'(ALU_ADD): begin
                short_res = add_w[WIDTH-1:0];
                short_c   = add_w[WIDTH];
                short_v   = (i0[WIDTH-1] == i1[WIDTH-1]) && (add_w[WIDTH-1] != i0[WIDTH-1]);
            end
            FUNC_W'(ALU_SUB): begin
                // Top bit of the widened difference is the borrow.
                short_res = sub_w[WIDTH-1:0];
                short_c   = sub_w[WIDTH];
                short_v   = (i0[WIDTH-1] != i1[WIDTH-1]) && (sub_w[WIDTH-1] != i0[WIDTH-1]);
            end
            FUNC_W'(ALU_MUL): is_long = 1'b1;
            FUNC_W'(ALU_DIV), FUNC_W'(ALU_MOD): begin
                is_long   = 1'b1;
                is_divmod = 1'b1;
            end
            default: short_known = 1'b0;
        endcase
        short_flags = short_known ? pack_flags(1'b0, short_v, short_c, short_res == '0) : '0;
    end

    assign op_div0 = is_divmod && (i1 == '0);

    always_comb begin
        long_res = iter_lo;
        long_v   = 1'b0;
        if (func_q == FUNC_W'(ALU_MUL)) begin
            long_v = |iter_hi;
        end else if (func_q == FUNC_W'(ALU_MOD)) begin
            long_res = iter_hi;
        end
        long_flags = pack_flags(1'b0, long_v, long_v, long_res == '0);
        div0_res   = (func_q == FUNC_W'(ALU_DIV)) ? {WIDTH{1'b1}} : i0_q;
        div0_flags = pack_flags(1'b1, 1'b0, 1'b0, div0_res == '0);
    end

    always_comb begin
        state_d    = state_q;
        o0_d       = o0_q;
        flags_d    = flags_q;
        i0_d       = i0_q;
        func_d     = func_q;
        div0_d     = div0_q;
        iter_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    i0_d   = i0;
                    func_d = func;
                    div0_d = op_div0;
                    if (is_long) begin
                        state_d    = ST_BUSY;
                        iter_start = !op_div0;
                    end else begin
                        state_d = ST_DONE;
                        o0_d    = short_res;
                        flags_d = short_flags;
                    end
                end
            end
            ST_BUSY: begin
                if (div0_q) begin
                    state_d = ST_DONE;
                    o0_d    = div0_res;
                    flags_d = div0_flags;
                end else if (iter_done) begin
                    state_d = ST_DONE;
                    o0_d    = long_res;
                    flags_d = long_flags;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            o0_q    <= '0;
            flags_q <= '0;
            i0_q    <= '0;
            func_q  <= '0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            o0_q    <= o0_d;
            flags_q <= flags_d;
            i0_q    <= i0_d;
            func_q  <= func_d;
            div0_q  <= div0_d;
        end
    end

    alu_seq_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (iter_start),
        .mode_div_i (func != FUNC_W'(ALU_MUL)),
        .a_i        (i0),
        .b_i        (i1),
        .done_o     (iter_done),
        .res_lo_o   (iter_lo),
        .res_hi_o   (iter_hi)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign o0        = o0_q;
    assign flags     = flags_q;

endmodule

`default_nettype wire
